nmos_tr_cnt: RTL and testbench

- Parametrised two-phase toggle-register counter: WIDTH master/slave cells clocked by PHI2/PHI1 enables sampled on one fast emulation clock.
- Generalises the single-bit toggle register: multi-bit, up/down, modulo-N, parallel load, synchronous clear, saturate option and terminal-count output.
- Used for NMOS chip models that need dividers, timers and address counters, e.g. video/timer counters.

---
 rtl/nmos_pkg.sv | 50 +++++
 rtl/nmos_tr_cell.sv | 35 +++
 rtl/nmos_tr_cnt.sv | 70 +++++++
 tb/tb_nmos_tr_cnt.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nmos_pkg.sv
// Shared definitions for the two-phase NMOS counter models: count direction
// constants, the next-state action encoding and a reusable modulo/saturating
// step function.
package nmos_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Width used for the count arithmetic so that MOD = 2**32 still fits and
    // an increment of the largest value never overflows silently.
    localparam int CNT_ARITH_W = 33;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_LD   = 2'd2,
        ACT_CNT  = 2'd3
    } nmos_act_e;

    // One count step inside 0..mod-1; sat=1 sticks at the range ends instead
    // of wrapping around.
    function automatic logic [CNT_ARITH_W-1:0] nmos_next_cnt(
        input logic [CNT_ARITH_W-1:0] val,
        input logic [CNT_ARITH_W-1:0] mod,
        input logic                   sat,
        input logic                   dir
    );
        logic [CNT_ARITH_W-1:0] last;
        logic [CNT_ARITH_W-1:0] inc;
        logic [CNT_ARITH_W-1:0] res;
        last = mod - 33'd1;
        inc  = val + 33'd1;
        res  = val;
        if (dir == DIR_UP) begin
            if (inc >= mod) begin
                res = sat ? last : 33'd0;
            end else begin
                res = inc;
            end
        end else begin
            if (val == 33'd0) begin
                res = sat ? 33'd0 : last;
            end else begin
                res = val - 33'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nmos_tr_cell.sv
// One-word master/slave register driven by two non-overlapping phase enables
// sampled on a single fast clock. The master captures the next value on PHI2,
// the slave copies the master on PHI1. Both load the reset value
// asynchronously.
module nmos_tr_cell #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phi1,
    input  logic             phi2,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] slave
);

    logic [WIDTH-1:0] master;

    // Both phases use pre-edge values, so an overlapping PHI1/PHI2 edge hands
    // the old master to the slave while the master takes the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            master <= RST_VAL;
            slave  <= RST_VAL;
        end else begin
            if (phi2) begin
                master <= nxt;
            end
            if (phi1) begin
                slave <= master;
            end
        end
    end

endmodule

// File: rtl/nmos_tr_cnt.sv
// Parametrised two-phase toggle-register counter: up/down, modulo-MOD,
// parallel load, synchronous clear, optional saturation and a terminal-count
// flag. Next-state logic lives here; storage is a single nmos_tr_cell.
module nmos_tr_cnt
    import nmos_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MOD     = 64'd1 << WIDTH,
    parameter bit              SAT     = 1'b0,
    parameter longint unsigned RST_VAL = 64'd0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             C1,
    input  logic             C2,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             T,
    input  logic             DIR,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [CNT_ARITH_W-1:0] MOD_EXT = CNT_ARITH_W'(MOD);
    localparam logic [WIDTH-1:0]       LAST    = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0]       RST_W   = WIDTH'(RST_VAL);

    nmos_act_e        act;
    logic [WIDTH-1:0] nxt;

    // Pick the PHI2 action by priority: clear beats load beats count.
    always_comb begin
        act = ACT_HOLD;
        if (CLR) begin
            act = ACT_CLR;
        end else if (LD) begin
            act = ACT_LD;
        end else if (T) begin
            act = ACT_CNT;
        end
    end

    // Value offered to the master; always computed from the slave so an
    // overlapping phase edge still sees the pre-edge count.
    always_comb begin
        nxt = Q;
        case (act)
            ACT_CLR: nxt = '0;
            ACT_LD:  nxt = WIDTH'(CNT_ARITH_W'(D) % MOD_EXT);
            ACT_CNT: nxt = WIDTH'(nmos_next_cnt(CNT_ARITH_W'(Q), MOD_EXT, SAT, DIR));
            default: nxt = Q;
        endcase
    end

    nmos_tr_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_W)
    ) u_cell (
        .clk   (CLK),
        .rst   (R),
        .phi1  (C1),
        .phi2  (C2),
        .nxt   (nxt),
        .slave (Q)
    );

    assign TC = T & ((DIR == DIR_DN) ? (Q == '0) : (Q == LAST));

endmodule

// File: tb/tb_nmos_tr_cnt.sv
// Self-checking bench for nmos_tr_cnt: a wrapping and a saturating MOD=10
// instance share all inputs and are compared against a behavioural model,
// a table of phase pairs and hand-written multi-cycle sequences.
module tb_nmos_tr_cnt;

    localparam int W    = 4;
    localparam int MODN = 10;
    localparam int RSTV = 5;

    logic         CLK = 1'b0;
    logic         R   = 1'b0;
    logic         C1  = 1'b0;
    logic         C2  = 1'b0;
    logic         CLR = 1'b0;
    logic         LD  = 1'b0;
    logic         T   = 1'b0;
    logic         DIR = 1'b0;
    logic [W-1:0] D   = '0;
    logic [W-1:0] q_w;
    logic [W-1:0] q_s;
    logic         tc_w;
    logic         tc_s;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = wrapping instance, 1 = saturating instance
    int m_master[2];
    int m_slave[2];

    typedef struct {
        logic         clr;
        logic         ld;
        logic         t;
        logic         dir;
        logic [W-1:0] d;
        int           q_w;
        logic         tc_w;
        int           q_s;
        logic         tc_s;
    } vec_t;

    vec_t vecs[17];

    // free-running emulation clock
    always #5 CLK = ~CLK;

    nmos_tr_cnt #(.WIDTH(W), .MOD(MODN), .SAT(1'b0), .RST_VAL(RSTV)) dut_w (
        .CLK(CLK), .R(R), .C1(C1), .C2(C2), .CLR(CLR), .LD(LD), .D(D),
        .T(T), .DIR(DIR), .Q(q_w), .TC(tc_w)
    );

    nmos_tr_cnt #(.WIDTH(W), .MOD(MODN), .SAT(1'b1), .RST_VAL(RSTV)) dut_s (
        .CLK(CLK), .R(R), .C1(C1), .C2(C2), .CLR(CLR), .LD(LD), .D(D),
        .T(T), .DIR(DIR), .Q(q_s), .TC(tc_s)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model_next(input int s, input bit sat);
        if (CLR) return 0;
        if (LD) return int'(D) % MODN;
        if (T && !DIR) begin
            if (sat) return (s + 1 > MODN - 1) ? MODN - 1 : s + 1;
            return (s + 1) % MODN;
        end
        if (T && DIR) begin
            if (sat) return (s == 0) ? 0 : s - 1;
            return (s + MODN - 1) % MODN;
        end
        return s;
    endfunction

    function automatic logic model_tc(input int i);
        return T && (DIR ? (m_slave[i] == 0) : (m_slave[i] == MODN - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_master[i] = RSTV;
            m_slave[i]  = RSTV;
        end
    endtask

    task automatic model_edge();
        int nm;
        int ns;
        if (R) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                nm = C2 ? model_next(m_slave[i], i == 1) : m_master[i];
                ns = C1 ? m_master[i] : m_slave[i];
                m_master[i] = nm;
                m_slave[i]  = ns;
            end
        end
    endtask

    // drive inputs at the falling edge, let one rising edge act, settle
    task automatic apply_stimulus(input logic c1, input logic c2, input logic clr,
                                  input logic ld, input logic [W-1:0] d,
                                  input logic t, input logic dir);
        @(negedge CLK);
        C1 = c1; C2 = c2; CLR = clr; LD = ld; D = d; T = t; DIR = dir;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic phase_pair(input logic clr, input logic ld, input logic [W-1:0] d,
                              input logic t, input logic dir);
        apply_stimulus(1'b0, 1'b1, clr, ld, d, t, dir);
        apply_stimulus(1'b1, 1'b0, clr, ld, d, t, dir);
    endtask

    task automatic check_output(input string tag);
        check({tag, "_q_w"}, 64'(q_w), 64'(m_slave[0]));
        check({tag, "_q_s"}, 64'(q_s), 64'(m_slave[1]));
        check({tag, "_tc_w"}, 64'(tc_w), 64'(model_tc(0)));
        check({tag, "_tc_s"}, 64'(tc_s), 64'(model_tc(1)));
    endtask

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // main test sequence
    initial begin
        // clear, then 10 up pairs (wrap vs saturate), load 2, 4 down pairs, hold
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1, 1'b0, 1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2, 1'b0, 2, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3, 1'b0, 3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4, 1'b0, 4, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5, 1'b0, 5, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 6, 1'b0, 6, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 7, 1'b0, 7, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8, 1'b0, 8, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 9, 1'b1, 9, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b0, 9, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 2, 1'b0, 2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1, 1'b0, 1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b1, 0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 9, 1'b0, 0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 8, 1'b0, 0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8, 1'b0, 0, 1'b0};

        $display("[TB] starting nmos_tr_cnt bench");

        // power-on reset
        #1 R = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("por_q_w", 64'(q_w), 64'(RSTV));
        check("por_q_s", 64'(q_s), 64'(RSTV));
        @(negedge CLK);
        R = 1'b0;

        // first pair after release counts normally
        phase_pair(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("post_rst_q_w", 64'(q_w), 64'd6);
        check("post_rst_q_s", 64'(q_s), 64'd6);
        phase_pair(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        // reset asserted between edges acts immediately
        @(negedge CLK);
        C1 = 1'b0; C2 = 1'b0;
        #1 R = 1'b1;
        #1;
        check("async_rst_q_w", 64'(q_w), 64'(RSTV));
        check("async_rst_q_s", 64'(q_s), 64'(RSTV));
        model_reset();
        @(negedge CLK);
        R = 1'b0;
        phase_pair(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("rst_again_q_w", 64'(q_w), 64'd6);

        // priority: clear over load over count, then load over count
        phase_pair(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        check("prio_clr_q_w", 64'(q_w), 64'd0);
        check("prio_clr_q_s", 64'(q_s), 64'd0);
        phase_pair(1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        check("prio_ld_q_w", 64'(q_w), 64'd7);
        check("prio_ld_q_s", 64'(q_s), 64'd7);

        // phase latency: Q moves only on the PHI1 edge
        phase_pair(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("lat_c2_q_w", 64'(q_w), 64'd3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("lat_c1_q_w", 64'(q_w), 64'd4);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("lat_c1only_q_w", 64'(q_w), 64'd4);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        check("idle_q_w", 64'(q_w), 64'd4);

        // overlap: master=4, slave=3, both phases on one edge
        phase_pair(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ovl_pre_q_w", 64'(q_w), 64'd3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ovl_q_w", 64'(q_w), 64'd4);
        check("ovl_q_s", 64'(q_s), 64'd4);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("ovl_post_q_w", 64'(q_w), 64'd4);
        check("ovl_post_q_s", 64'(q_s), 64'd4);

        // table: wrap, saturation, terminal count
        for (int i = 0; i < 17; i++) begin
            phase_pair(vecs[i].clr, vecs[i].ld, vecs[i].d, vecs[i].t, vecs[i].dir);
            check($sformatf("vec%0d_q_w", i), 64'(q_w), 64'(vecs[i].q_w));
            check($sformatf("vec%0d_tc_w", i), 64'(tc_w), 64'(vecs[i].tc_w));
            check($sformatf("vec%0d_q_s", i), 64'(q_s), 64'(vecs[i].q_s));
            check($sformatf("vec%0d_tc_s", i), 64'(tc_s), 64'(vecs[i].tc_s));
        end

        // random phases, including overlap and idle edges
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0),
                           W'($urandom_range(0, MODN - 1)), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 1)));
            check_output($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
